freqin_scan_ctrl: RTL and testbench



---
 rtl/freqin_pkg.sv | 28 ++
 rtl/freqin_rr_pick.sv | 37 +++
 rtl/freqin_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_freqin_scan_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freqin_pkg.sv
// Shared types and helpers for the frequency-input scan controller.
package freqin_pkg;

   localparam int PERIOD_W = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_ARM,
      S_MEASURE,
      S_STORE,
      S_TIMEOUT,
      S_NEXT
   } state_e;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >>> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/freqin_rr_pick.sv
// Round-robin finder: next enabled channel after (or at) the current one.
module freqin_rr_pick
   import freqin_pkg::*;
#(
   parameter int CHANNELS = 4
) (
   input  logic [CHANNELS-1:0] mask_i,
   input  logic [3:0]          cur_i,
   input  logic                incl_cur_i,
   output logic [3:0]          next_o,
   output logic                wrap_o
);

   logic found;

   always_comb begin
      next_o = '0;
      wrap_o = 1'b0;
      found  = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!found && mask_i[i] &&
             ((i > int'(cur_i)) ||
              (incl_cur_i && (i == int'(cur_i))))) begin
            next_o = 4'(i);
            found  = 1'b1;
         end
      end
      // Nothing at or above cur: wrap to the lowest enabled channel.
      if (!found) begin
         wrap_o = 1'b1;
         for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (mask_i[i]) next_o = 4'(i);
         end
      end
   end

endmodule

// File: rtl/freqin_scan_ctrl.sv
// Shares one period counter across CHANNELS frequency inputs, round-robin.
module freqin_scan_ctrl
   import freqin_pkg::*;
#(
   parameter int CHANNELS  = 4,
   parameter int RESET_CNT = 25000000,
   parameter int SETTLE    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [CHANNELS-1:0]    freq,
   input  logic [CHANNELS-1:0]    enable_mask,
   output logic [32*CHANNELS-1:0] period,
   output logic [CHANNELS-1:0]    valid,
   output logic [3:0]             cur_channel,
   output logic                   scan_done
);

   localparam int CW = clog2(RESET_CNT + 1) + 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(RESET_CNT);
   localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [CW-1:0]       res_q, res_d;
   logic [3:0]          cur_q, cur_d;
   logic [CHANNELS-1:0] sync1_q, sync2_q;
   logic                sel_d_q;
   logic [PERIOD_W-1:0] per_q [CHANNELS];
   logic [CHANNELS-1:0] valid_q;

   logic [15:0] sync_pad;
   logic [15:0] mask_pad;
   logic        sel;
   logic        rise;
   logic        any_en;
   logic        cur_en;
   logic [3:0]  pick_idx;
   logic        pick_wrap;
   logic        wr_en;
   logic        wr_ok;

   assign sync_pad = 16'(sync2_q);
   assign mask_pad = 16'(enable_mask);
   assign sel      = sync_pad[cur_q];
   assign rise     = sel & ~sel_d_q;
   assign any_en   = |enable_mask;
   assign cur_en   = mask_pad[cur_q];

   freqin_rr_pick #(
      .CHANNELS(CHANNELS)
   ) u_pick (
      .mask_i    (enable_mask),
      .cur_i     (cur_q),
      .incl_cur_i(state_q == S_IDLE),
      .next_o    (pick_idx),
      .wrap_o    (pick_wrap)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      cur_d     = cur_q;
      scan_done = 1'b0;
      wr_en     = 1'b0;
      wr_ok     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (any_en) begin
               cur_d   = pick_idx;
               cnt_d   = '0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q + 1'b1;
            if (!cur_en) begin
               state_d = S_NEXT;
            end else if (cnt_q >= SET_LAST) begin
               cnt_d   = '0;
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            cnt_d = cnt_q + 1'b1;
            if (!cur_en) begin
               state_d = S_NEXT;
            end else if (rise) begin
               cnt_d   = '0;
               state_d = S_MEASURE;
            end else if (cnt_q > CNT_MAX) begin
               state_d = S_TIMEOUT;
            end
         end
         S_MEASURE: begin
            cnt_d = cnt_q + 1'b1;
            if (!cur_en) begin
               state_d = S_NEXT;
            end else if (rise) begin
               res_d   = cnt_q + 1'b1;
               state_d = S_STORE;
            end else if (cnt_q > CNT_MAX) begin
               state_d = S_TIMEOUT;
            end
         end
         S_STORE: begin
            wr_en   = 1'b1;
            wr_ok   = 1'b1;
            state_d = S_NEXT;
         end
         S_TIMEOUT: begin
            wr_en   = 1'b1;
            state_d = S_NEXT;
         end
         S_NEXT: begin
            if (!any_en) begin
               state_d = S_IDLE;
            end else begin
               cur_d     = pick_idx;
               scan_done = pick_wrap;
               cnt_d     = '0;
               state_d   = S_SETTLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         res_q   <= '0;
         cur_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         sel_d_q <= 1'b0;
         valid_q <= '0;
         for (int i = 0; i < CHANNELS; i++) per_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         cur_q   <= cur_d;
         sync1_q <= freq;
         sync2_q <= sync1_q;
         sel_d_q <= sel;
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && (cur_q == 4'(i))) begin
               per_q[i]   <= wr_ok ? PERIOD_W'(res_q) : '0;
               valid_q[i] <= wr_ok;
            end
            // A disabled channel is cleared, overriding any store.
            if (!enable_mask[i]) begin
               per_q[i]   <= '0;
               valid_q[i] <= 1'b0;
            end
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_out
      assign period[32*g +: 32] = per_q[g];
   end

   assign valid       = valid_q;
   assign cur_channel = cur_q;

endmodule

// File: tb/tb_freqin_scan_ctrl.sv
// Scoreboard bench for freqin_scan_ctrl: directed scan scenarios.
module tb_freqin_scan_ctrl;

   localparam int CH = 4;

   typedef struct {
      int   ch;
      int   per;
      logic vld;
   } upd_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [CH-1:0]     mask = '0;
   wire  [CH-1:0]     freq;
   logic [32*CH-1:0]  period;
   logic [CH-1:0]     valid;
   logic [3:0]        cur_channel;
   logic              scan_done;

   int   hp [CH] = '{5, 10, 15, 20};
   logic lvl [CH] = '{default: 1'b0};

   int   errors = 0;
   int   checks = 0;
   int   sd_cnt = 0;
   logic chk_cur = 1'b0;
   upd_t upd_q[$];
   int   cur_q[$];

   logic [32*CH-1:0] prev_per = '0;
   logic [CH-1:0]    prev_vld = '0;
   logic [3:0]       prev_cur = '0;

   always #5 clk = ~clk;

   freqin_scan_ctrl #(
      .CHANNELS (CH),
      .RESET_CNT(100),
      .SETTLE   (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .freq       (freq),
      .enable_mask(mask),
      .period     (period),
      .valid      (valid),
      .cur_channel(cur_channel),
      .scan_done  (scan_done)
   );

   for (genvar g = 0; g < CH; g++) begin : gen
      logic f = 1'b0;
      int   c = 0;
      always @(posedge clk) begin
         #3;
         if (hp[g] == 0) begin
            f = lvl[g];
            c = 0;
         end else begin
            c = c + 1;
            if (c >= hp[g]) begin
               f = ~f;
               c = 0;
            end
         end
      end
      assign freq[g] = f;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push_upd(input int ch, input int per, input logic v);
      upd_t e;
      e.ch  = ch;
      e.per = per;
      e.vld = v;
      upd_q.push_back(e);
   endtask

   task automatic wait_empty(input int bound, input string nm);
      int n = 0;
      while ((upd_q.size() != 0 || cur_q.size() != 0) && n < bound) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (upd_q.size() != 0 || cur_q.size() != 0) begin
         errors++;
         $display("FAIL %s: pending upd=%0d cur=%0d after %0d cycles, need 0",
                  nm, upd_q.size(), cur_q.size(), bound);
         upd_q.delete();
         cur_q.delete();
      end
   endtask

   task automatic wait_cur(input int v, input int bound, input string nm);
      int n = 0;
      while (int'(cur_channel) != v && n < bound) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(nm, cur_channel, v);
   endtask

   always @(negedge clk) begin
      upd_t e;
      int   ec;
      if (rst_n) begin
         for (int i = 0; i < CH; i++) begin
            if (period[32*i +: 32] != prev_per[32*i +: 32] ||
                valid[i] != prev_vld[i]) begin
               if (upd_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_update ch%0d: got period %0d valid %0b, none expected",
                           i, period[32*i +: 32], valid[i]);
               end else begin
                  e = upd_q.pop_front();
                  chk("upd_channel", i, e.ch);
                  chk($sformatf("upd_ch%0d_period", i), period[32*i +: 32], e.per);
                  chk($sformatf("upd_ch%0d_valid", i), valid[i], e.vld);
               end
            end
         end
         if (chk_cur && cur_channel != prev_cur) begin
            if (cur_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_cur_change: got %0d, no change expected",
                        cur_channel);
            end else begin
               ec = cur_q.pop_front();
               chk("cur_sequence", cur_channel, ec);
            end
         end
      end
      prev_per = period;
      prev_vld = valid;
      prev_cur = cur_channel;
      if (scan_done) sd_cnt++;
   end

   initial begin
      int n;
      int sd0;

      repeat (3) @(negedge clk);
      for (int i = 0; i < CH; i++) chk("rst_period", period[32*i +: 32], 0);
      chk("rst_valid", valid, 0);
      chk("rst_cur", cur_channel, 0);
      chk("rst_scan_done", scan_done, 0);
      #1 rst_n = 1'b1;

      // Single channel, period 10.
      @(negedge clk);
      #1;
      mask = 4'b0001;
      push_upd(0, 10, 1'b1);
      wait_empty(200, "p1_first_meas");
      sd0 = sd_cnt;
      repeat (150) @(negedge clk);
      #1;
      chk("p1_scan_done_repeats_ge3", (sd_cnt - sd0) >= 3, 1);
      chk("p1_cur_stays_0", cur_channel, 0);

      // All four channels, periods 10/20/30/40.
      mask = 4'b1111;
      sd0 = sd_cnt;
      cur_q = '{1, 2, 3, 0};
      push_upd(1, 20, 1'b1);
      push_upd(2, 30, 1'b1);
      push_upd(3, 40, 1'b1);
      chk_cur = 1'b1;
      wait_empty(600, "p2_pass1");
      chk("p2_scan_done_pass1", sd_cnt - sd0, 1);
      for (int i = 0; i < CH; i++)
         chk($sformatf("p2_period_ch%0d", i), period[32*i +: 32], 10 * (i + 1));
      chk("p2_valid_all", valid, 4'b1111);
      sd0 = sd_cnt;
      cur_q = '{1, 2, 3, 0};
      wait_empty(600, "p2_pass2");
      chk("p2_scan_done_pass2", sd_cnt - sd0, 1);
      chk_cur = 1'b0;

      // ch2 stuck low times out; ch3 retimed to period 24.
      hp[2]  = 0;
      lvl[2] = 1'b0;
      hp[3]  = 12;
      push_upd(2, 0, 1'b0);
      push_upd(3, 24, 1'b1);
      wait_cur(2, 300, "p3_reach_ch2");
      n = 0;
      while (valid[2] && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk($sformatf("p3_timeout_latency_in_100_112(n=%0d)", n),
          (n >= 100 && n <= 112), 1);
      wait_empty(300, "p3_ch3_meas");

      // Sparse mask 1010.
      hp[2] = 15;
      mask  = 4'b1010;
      push_upd(0, 0, 1'b0);
      wait_cur(1, 200, "p4_reach_ch1");
      cur_q = '{3, 1, 3, 1};
      chk_cur = 1'b1;
      wait_empty(600, "p4_alternate");
      chk_cur = 1'b0;
      chk("p4_valid0", valid[0], 0);
      chk("p4_valid2", valid[2], 0);
      chk("p4_period0", period[31:0], 0);
      chk("p4_period2", period[95:64], 0);

      // Clear ch1 mask bit during its MEASURE.
      wait_cur(3, 200, "p5_reach_ch3");
      hp[1]  = 0;
      lvl[1] = 1'b0;
      wait_cur(1, 200, "p5_reach_ch1");
      repeat (5) @(negedge clk);
      #1;
      lvl[1] = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      mask = 4'b1000;
      push_upd(1, 0, 1'b0);
      @(negedge clk);
      #1;
      chk("p5_period1_cleared", period[63:32], 0);
      chk("p5_valid1_cleared", valid[1], 0);
      wait_cur(3, 4, "p5_next_is_ch3");

      // Fill all four, then reset mid-MEASURE on ch2.
      hp[1] = 10;
      mask  = 4'b1111;
      push_upd(0, 10, 1'b1);
      push_upd(1, 20, 1'b1);
      push_upd(2, 30, 1'b1);
      wait_empty(800, "p6_fill_all");
      hp[2]  = 0;
      lvl[2] = 1'b0;
      chk("p6_all_valid", valid, 4'b1111);
      wait_cur(2, 400, "p6_reach_ch2");
      repeat (5) @(negedge clk);
      #1;
      lvl[2] = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < CH; i++) chk("p6_rst_period", period[32*i +: 32], 0);
      chk("p6_rst_valid", valid, 0);
      chk("p6_rst_cur", cur_channel, 0);
      chk("p6_rst_scan_done", scan_done, 0);
      repeat (3) @(negedge clk);
      #1;
      rst_n  = 1'b1;
      hp[2]  = 15;
      lvl[2] = 1'b0;
      chk("p6_restart_cur", cur_channel, 0);
      cur_q = '{1, 2, 3, 0};
      chk_cur = 1'b1;
      push_upd(0, 10, 1'b1);
      push_upd(1, 20, 1'b1);
      push_upd(2, 30, 1'b1);
      push_upd(3, 24, 1'b1);
      wait_empty(800, "p6_after_reset");
      chk_cur = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
